// File: rtl/gb_pixel_stream_tx.sv
// AXI4-Stream pixel transmitter: buffers host pixels in a small FIFO and emits
// one IMG_W x IMG_H frame per start, with TLAST and raster position of each beat.
module gb_pixel_stream_tx #(
    parameter int DATA_W     = 8,
    parameter int IMG_W      = 488,
    parameter int IMG_H      = 648,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [DATA_W-1:0] pix_in_data,
    input  logic              pix_in_valid,
    output logic              pix_in_ready,
    output logic [DATA_W-1:0] arg_1_TDATA,
    output logic              arg_1_TVALID,
    input  logic              arg_1_TREADY,
    output logic              arg_1_TLAST,
    output logic [8:0]        tx_x,
    output logic [9:0]        tx_y
);
    localparam int               PTR_W     = $clog2(FIFO_DEPTH);
    localparam int               CNT_W     = PTR_W + 1;
    localparam logic [18:0]      FRAME_PIX = 19'(IMG_W * IMG_H);
    localparam logic [8:0]       LAST_X    = 9'(IMG_W - 1);
    localparam logic [9:0]       LAST_Y    = 10'(IMG_H - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic [18:0]       r_in_cnt;
    logic [8:0]        r_tx_x;
    logic [9:0]        r_tx_y;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_last_pos;

    // Ready depends only on registered state, so TREADY never reaches pix_in_ready.
    assign w_full       = (r_count == FULL_CNT);
    assign w_empty      = (r_count == '0);
    assign pix_in_ready = (r_state == S_STREAM) & ~w_full & (r_in_cnt < FRAME_PIX);
    assign w_push       = pix_in_valid & pix_in_ready;
    assign arg_1_TVALID = ~w_empty;
    assign w_pop        = arg_1_TVALID & arg_1_TREADY;
    assign w_last_pos   = (r_tx_x == LAST_X) && (r_tx_y == LAST_Y);
    assign arg_1_TLAST  = arg_1_TVALID & w_last_pos;
    assign arg_1_TDATA  = r_mem[r_rd_ptr];
    assign busy         = r_busy;
    assign done         = r_done;
    assign tx_x         = r_tx_x;
    assign tx_y         = r_tx_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            // NOTE: the storage is tiny and cleared on reset so TDATA reads 0 afterwards;
            // larger memories should normally be left unreset.
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= pix_in_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_in_cnt <= '0;
            r_tx_x   <= '0;
            r_tx_y   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_STREAM;
                        r_busy   <= 1'b1;
                        r_in_cnt <= '0;
                        r_tx_x   <= '0;
                        r_tx_y   <= '0;
                    end
                end
                S_STREAM: begin
                    if (w_push) r_in_cnt <= r_in_cnt + 19'd1;
                    if (w_pop) begin
                        if (w_last_pos) begin
                            r_tx_x  <= '0;
                            r_tx_y  <= '0;
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (r_tx_x == LAST_X) begin
                            r_tx_x <= '0;
                            r_tx_y <= r_tx_y + 10'd1;
                        end else begin
                            r_tx_x <= r_tx_x + 9'd1;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gb_pixel_stream_tx.sv
// Randomised bench for gb_pixel_stream_tx on a 4x2 frame; beats are compared
// against a queue of accepted pixels and positions derived from the beat index.
module tb_gb_pixel_stream_tx;
    localparam int W     = 4;
    localparam int H     = 2;
    localparam int FRAME = W * H;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [8:0] x;
        logic [9:0] y;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy, done;
    logic [7:0] pix_in_data = '0;
    logic       pix_in_valid = 1'b0;
    logic       pix_in_ready;
    logic [7:0] arg_1_TDATA;
    logic       arg_1_TVALID;
    logic       tready = 1'b0;
    logic       arg_1_TLAST;
    logic [8:0] tx_x;
    logic [9:0] tx_y;

    beat_t      obs_q[$];
    logic [7:0] acc_q[$];
    int done_cnt, last_cnt, cyc, done_cyc, last_cyc;
    int n_checks = 0;
    int n_pass   = 0;

    gb_pixel_stream_tx #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .pix_in_data(pix_in_data), .pix_in_valid(pix_in_valid), .pix_in_ready(pix_in_ready),
        .arg_1_TDATA(arg_1_TDATA), .arg_1_TVALID(arg_1_TVALID), .arg_1_TREADY(tready),
        .arg_1_TLAST(arg_1_TLAST), .tx_x(tx_x), .tx_y(tx_y)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Beat idx of a stream of frames: raster position follows from idx alone.
    function automatic beat_t model_beat(input int idx, input logic [7:0] d);
        beat_t b;
        int k;
        k      = idx % FRAME;
        b.data = d;
        b.last = (k == FRAME - 1);
        b.x    = 9'(k % W);
        b.y    = 10'(k / W);
        return b;
    endfunction

    // One clock: record handshakes that complete at the coming edge, end at next negedge.
    task automatic cycle();
        beat_t b;
        #1;
        if (arg_1_TVALID === 1'b1 && tready) begin
            b.data = arg_1_TDATA; b.last = arg_1_TLAST; b.x = tx_x; b.y = tx_y;
            obs_q.push_back(b);
            if (arg_1_TLAST === 1'b1) begin last_cnt++; last_cyc = cyc; end
        end
        if (pix_in_valid && pix_in_ready === 1'b1) acc_q.push_back(pix_in_data);
        if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_obs();
        obs_q.delete(); acc_q.delete();
        done_cnt = 0; last_cnt = 0; done_cyc = -1; last_cyc = -1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; pix_in_valid = 1'b0; tready = 1'b0; pix_in_data = '0;
    endtask

    task automatic issue_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        cycle(); cycle();
        rst = 1'b0;
        repeat (5) cycle();
        n_checks++;
        if ({arg_1_TVALID, pix_in_ready, busy, done, arg_1_TLAST} !== 5'b0)
            $display("FAIL reset_flags got tvalid/ready/busy/done/tlast=%b want=00000",
                     {arg_1_TVALID, pix_in_ready, busy, done, arg_1_TLAST});
        else n_pass++;
        n_checks++;
        if (arg_1_TDATA !== 8'h00) $display("FAIL reset_tdata got=%h want=00", arg_1_TDATA);
        else n_pass++;
        n_checks++;
        if ({tx_x, tx_y} !== 19'd0) $display("FAIL reset_pos got x=%0d y=%0d want 0/0", tx_x, tx_y);
        else n_pass++;
    endtask

    task automatic test_single_frame();
        int budget = 100;
        beat_t e;
        clear_obs();
        issue_start();
        n_checks++;
        if (busy !== 1'b1) $display("FAIL single_busy got=%b want=1", busy); else n_pass++;
        tready = 1'b1;
        while (done_cnt == 0 && budget > 0) begin
            pix_in_valid = (acc_q.size() < FRAME);
            pix_in_data  = 8'(8'h10 + acc_q.size());
            cycle();
            budget--;
        end
        idle_inputs();
        repeat (3) cycle();
        n_checks++;
        if (budget == 0) $display("FAIL single_timeout got=no done want=done"); else n_pass++;
        n_checks++;
        if (obs_q.size() != FRAME) $display("FAIL single_count got=%0d want=%0d", obs_q.size(), FRAME);
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < FRAME; i++) begin
            e = model_beat(i, 8'(8'h10 + i));
            n_checks++;
            if (obs_q[i] !== e)
                $display("FAIL single_beat%0d got d=%h l=%b x=%0d y=%0d want d=%h l=%b x=%0d y=%0d", i,
                         obs_q[i].data, obs_q[i].last, obs_q[i].x, obs_q[i].y, e.data, e.last, e.x, e.y);
            else n_pass++;
        end
        n_checks++;
        if (done_cnt != 1 || last_cnt != 1)
            $display("FAIL single_pulses got done=%0d tlast=%0d want 1/1", done_cnt, last_cnt);
        else n_pass++;
        n_checks++;
        if (done_cyc != last_cyc + 1)
            $display("FAIL single_done_timing got done_cyc=%0d want=%0d", done_cyc, last_cyc + 1);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int budget = 100;
        bit stable = 1'b1;
        beat_t e;
        clear_obs();
        issue_start();
        tready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            pix_in_valid = 1'b1;
            pix_in_data  = 8'(8'h10 + acc_q.size());
            cycle();
            if (c == 0) begin
                n_checks++;
                if (arg_1_TVALID !== 1'b1 || arg_1_TDATA !== 8'h10)
                    $display("FAIL bp_latency got tvalid=%b tdata=%h want 1/10", arg_1_TVALID, arg_1_TDATA);
                else n_pass++;
            end
            if (arg_1_TVALID !== 1'b1 || arg_1_TDATA !== 8'h10) stable = 1'b0;
        end
        n_checks++;
        if (acc_q.size() != 4 || pix_in_ready !== 1'b0)
            $display("FAIL bp_full got accepted=%0d ready=%b want 4/0", acc_q.size(), pix_in_ready);
        else n_pass++;
        n_checks++;
        if (!stable || obs_q.size() != 0)
            $display("FAIL bp_hold got stable=%0b beats=%0d want 1/0", stable, obs_q.size());
        else n_pass++;
        tready = 1'b1;
        while (done_cnt == 0 && budget > 0) begin
            pix_in_valid = (acc_q.size() < FRAME);
            pix_in_data  = 8'(8'h10 + acc_q.size());
            cycle();
            budget--;
        end
        idle_inputs();
        cycle();
        n_checks++;
        if (budget == 0 || obs_q.size() != FRAME || done_cnt != 1)
            $display("FAIL bp_frame got beats=%0d done=%0d budget=%0d want %0d/1/>0",
                     obs_q.size(), done_cnt, budget, FRAME);
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < FRAME; i++) begin
            e = model_beat(i, 8'(8'h10 + i));
            n_checks++;
            if (obs_q[i] !== e)
                $display("FAIL bp_beat%0d got d=%h l=%b x=%0d y=%0d want d=%h l=%b x=%0d y=%0d", i,
                         obs_q[i].data, obs_q[i].last, obs_q[i].x, obs_q[i].y, e.data, e.last, e.x, e.y);
            else n_pass++;
        end
    endtask

    task automatic test_random_frames();
        int budget = 2000;
        beat_t e;
        clear_obs();
        for (int f = 0; f < 2; f++) begin
            issue_start();
            while (done_cnt == f && budget > 0) begin
                tready       = ($urandom_range(99) < 60);
                pix_in_valid = (acc_q.size() < (f + 1) * FRAME) && ($urandom_range(99) < 70);
                pix_in_data  = 8'($urandom);
                start        = ($urandom_range(3) == 0);
                cycle();
                budget--;
            end
            start = 1'b0;
        end
        n_checks++;
        if (busy !== 1'b0) $display("FAIL rand_busy_after got=%b want=0", busy); else n_pass++;
        idle_inputs();
        repeat (3) cycle();
        n_checks++;
        if (budget == 0) $display("FAIL rand_timeout got=no done want=done"); else n_pass++;
        n_checks++;
        if (acc_q.size() != 2 * FRAME || obs_q.size() != 2 * FRAME)
            $display("FAIL rand_count got accepted=%0d beats=%0d want %0d", acc_q.size(), obs_q.size(), 2 * FRAME);
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < acc_q.size(); i++) begin
            e = model_beat(i, acc_q[i]);
            n_checks++;
            if (obs_q[i] !== e)
                $display("FAIL rand_beat%0d got d=%h l=%b x=%0d y=%0d want d=%h l=%b x=%0d y=%0d", i,
                         obs_q[i].data, obs_q[i].last, obs_q[i].x, obs_q[i].y, e.data, e.last, e.x, e.y);
            else n_pass++;
        end
        n_checks++;
        if (last_cnt != 2 || done_cnt != 2)
            $display("FAIL rand_pulses got tlast=%0d done=%0d want 2/2", last_cnt, done_cnt);
        else n_pass++;
    endtask

    task automatic test_overflow_refused();
        int budget = 100;
        clear_obs();
        issue_start();
        tready = 1'b1;
        while (acc_q.size() < FRAME && budget > 0) begin
            pix_in_valid = 1'b1;
            pix_in_data  = 8'(8'hA0 + acc_q.size());
            cycle();
            budget--;
        end
        tready       = 1'b0;
        pix_in_valid = 1'b1;
        pix_in_data  = 8'hA8;
        n_checks++;
        if (pix_in_ready !== 1'b0) $display("FAIL ovf_ready got=%b want=0", pix_in_ready); else n_pass++;
        repeat (3) cycle();
        n_checks++;
        if (acc_q.size() != FRAME || pix_in_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL ovf_stall got accepted=%0d ready=%b busy=%b want %0d/0/1",
                     acc_q.size(), pix_in_ready, busy, FRAME);
        else n_pass++;
        tready = 1'b1;
        while (done_cnt == 0 && budget > 0) begin
            cycle();
            budget--;
        end
        idle_inputs();
        cycle();
        n_checks++;
        if (budget == 0 || acc_q.size() != FRAME || obs_q.size() != FRAME)
            $display("FAIL ovf_frame got accepted=%0d beats=%0d budget=%0d want %0d/%0d/>0",
                     acc_q.size(), obs_q.size(), budget, FRAME, FRAME);
        else n_pass++;
        n_checks++;
        if (obs_q.size() == FRAME && (obs_q[FRAME-1].data !== 8'hA7 || obs_q[FRAME-1].last !== 1'b1))
            $display("FAIL ovf_last got d=%h l=%b want a7/1", obs_q[FRAME-1].data, obs_q[FRAME-1].last);
        else n_pass++;
    endtask

    task automatic test_mid_frame_reset();
        int budget = 100;
        beat_t e;
        clear_obs();
        issue_start();
        tready = 1'b1;
        while (obs_q.size() < 3 && budget > 0) begin
            pix_in_valid = (acc_q.size() < FRAME);
            pix_in_data  = 8'(8'h30 + acc_q.size());
            cycle();
            budget--;
        end
        idle_inputs();
        rst = 1'b1;
        cycle();
        n_checks++;
        if ({arg_1_TVALID, busy, pix_in_ready, done} !== 4'b0 || arg_1_TDATA !== 8'h00 || {tx_x, tx_y} !== 19'd0)
            $display("FAIL rst_abort got tvalid/busy/ready/done=%b tdata=%h x=%0d y=%0d want 0000/00/0/0",
                     {arg_1_TVALID, busy, pix_in_ready, done}, arg_1_TDATA, tx_x, tx_y);
        else n_pass++;
        rst = 1'b0;
        cycle();
        clear_obs();
        issue_start();
        tready = 1'b1;
        budget = 100;
        while (done_cnt == 0 && budget > 0) begin
            pix_in_valid = (acc_q.size() < FRAME);
            pix_in_data  = 8'(8'h50 + acc_q.size());
            cycle();
            budget--;
        end
        idle_inputs();
        cycle();
        n_checks++;
        if (budget == 0 || obs_q.size() != FRAME || done_cnt != 1)
            $display("FAIL rst_refr got beats=%0d done=%0d budget=%0d want %0d/1/>0",
                     obs_q.size(), done_cnt, budget, FRAME);
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < FRAME; i++) begin
            e = model_beat(i, 8'(8'h50 + i));
            n_checks++;
            if (obs_q[i] !== e)
                $display("FAIL rst_beat%0d got d=%h l=%b x=%0d y=%0d want d=%h l=%b x=%0d y=%0d", i,
                         obs_q[i].data, obs_q[i].last, obs_q[i].x, obs_q[i].y, e.data, e.last, e.x, e.y);
            else n_pass++;
        end
    endtask

    initial begin
        cyc = 0;
        clear_obs();
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_backpressure();
        test_random_frames();
        test_overflow_refused();
        test_mid_frame_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
